char_classifier: RTL and testbench
==================================

# char_classifier

Front-end stage of the string-recognition pipeline: accepts raw ASCII bytes with a valid/ready handshake and classifies each byte into the character-class flags consumed by the downstream recognizer FSM. Results are buffered in a 2-entry FIFO and presented one character per handshake. A per-string length counter also raises `verify_error` on overlong strings and non-ASCII bytes. Strings are delimited by `\0` (0x00).

## Interface
- `MAX_LEN`, 15: maximum number of non-`\0` bytes allowed in one string.
- `LEN_W`, 4: width of the length counter; must hold `MAX_LEN`.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `in_data`  in  8  input byte.
- `in_valid`  in  1  `in_data` is offered.
- `in_ready`  out  1  stage can accept a byte.
- `out_ready`  in  1  consumer takes the head character; tie high for a free-running consumer.
- `valid`  out  1  head entry is presented.
- `start_stop`, `small_letter`, `capital_letter`, `number`, `hex_digit`, `punctuation_basic`, `punctuation_finance`, `parentheses`, `curly_braces`, `math_symbol`, `whitespace`, `vowel`, `consonant`, `other`  out  1 each  class flags of the head entry.
- `verify_error`  out  1  head entry violates the length or ASCII rule.
- `str_len`  out  LEN_W  count of non-`\0` bytes in the current string, including the head entry; 0 for `\0`.

## Operation
Classification is combinational on `in_data` and stored with the entry at write time.
- `start_stop`: 0x00.
- `small_letter`: a–z.
- `capital_letter`: A–Z.
- `number`: 0–9.
- `hex_digit`: 0–9, A–F, a–f.
- `punctuation_basic`: `. , : ; ! ? ' "`.
- `punctuation_finance`: `# $ % & @`.
- `parentheses`: `( ) [ ]`.
- `curly_braces`: `{ }`.
- `math_symbol`: `+ - * / \ = < >`.
- `whitespace`: 0x20, 0x09, 0x0A, 0x0D.
- `vowel`: aeiouAEIOU.
- `consonant`: a letter that is not a vowel.
- `other`: none of `start_stop`, letter, digit, punctuation, bracket, math or whitespace.
- Overlap: `hex_digit`, `vowel` and `consonant` overlap the letter/digit flags; all other flags are mutually exclusive.

Length counter `len` (LEN_W bits), updated on each accepted byte:
- `\0`: the entry stores `str_len`=0 and `verify_error`=0; `len` and `ovf` then clear to 0.
- Other byte, `len` < `MAX_LEN`: `len` increments, and the entry stores the new value.
- Other byte, `len` = `MAX_LEN`: `len` saturates and sets sticky `ovf`.
- Entry `verify_error` = `ovf`, including the byte that sets `ovf`, OR `in_data[7]`.
- A byte ≥0x80 also sets `other`=1; it does not set `ovf`.

FIFO, 2 entries, each holding 14 flags, `verify_error` and `str_len`:
- Write: `in_valid && in_ready`.
- Read: `valid && out_ready`.
- `in_ready` = (count < 2). No write bypass when full, even if a read happens in the same cycle.
- Simultaneous write and read at count 1: count stays 1; the new entry becomes the head at the next edge.
- Outputs are driven from registered head storage. When the FIFO is empty, `valid`=0 and all flags, `verify_error` and `str_len` are 0.

## Timing
- Reset (async, takes effect immediately):
  - count=0; `valid`=0; all flags, `verify_error` and `str_len` are 0.
  - `len`=0, `ovf`=0.
  - `in_ready`=0 while `rst`=1, and 1 from the first cycle after release.
- Latency: a byte accepted at edge N with the FIFO empty appears with `valid`=1 in the cycle after edge N.
- Throughput: one byte per cycle with `out_ready` held high.
- Head outputs are stable while `valid`=1 and `out_ready`=0.
- Reset mid-string discards FIFO contents and the length count; the next byte starts a fresh string.
- `in_data` is ignored when `in_valid`=0 or `in_ready`=0.

## Test plan
- Stream `\0`,`1`,`2`,`+`,`A`,`\0` with `out_ready`=1 → six `valid` pulses, one per cycle after the first edge.
  - Flags: `start_stop`; `number`+`hex_digit`; `number`+`hex_digit`; `math_symbol`; `capital_letter`+`hex_digit`+`vowel`; `start_stop`.
  - `str_len`: 0,1,2,3,4,0.
- Hold `out_ready`=0, offer 3 bytes → `in_ready`=0 after the second accept. The third byte is held until `out_ready`=1 and is delivered in order with no loss or duplication.
- Send 16 `b` bytes after `\0` with `MAX_LEN`=15.
  - Bytes 1–15: `consonant`+`small_letter`+`hex_digit`, `verify_error`=0.
  - Byte 16: `verify_error`=1, `str_len`=15.
  - The following `\0` has `verify_error`=0, and the next string's byte 1 has `str_len`=1.
- Send 0xC8, `@`, `{`, `TAB` → `other`+`verify_error`; `punctuation_finance`; `curly_braces`; `whitespace`.
- Assert `rst` asynchronously mid-cycle with 2 entries buffered → `valid`=0 and all outputs 0 before the next edge, `in_ready`=0 during reset. After release, the next byte gets `str_len`=1.
- Random `in_valid`/`out_ready` with 1000 bytes → output order and flags match the reference classifier model; no overflow or underflow.

Source files
------------

// File: rtl/char_classifier.sv
// ASCII byte classifier for the string recognizer: per-byte class flags, per-string
// length/ASCII check, results buffered in a 2-entry FIFO with valid/ready on both sides.
module char_classifier #(
    parameter int unsigned MAX_LEN = 15,
    parameter int unsigned LEN_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             out_ready,
    output logic             valid,
    output logic             start_stop,
    output logic             small_letter,
    output logic             capital_letter,
    output logic             number,
    output logic             hex_digit,
    output logic             punctuation_basic,
    output logic             punctuation_finance,
    output logic             parentheses,
    output logic             curly_braces,
    output logic             math_symbol,
    output logic             whitespace,
    output logic             vowel,
    output logic             consonant,
    output logic             other,
    output logic             verify_error,
    output logic [LEN_W-1:0] str_len
);

    typedef struct packed {
        logic             start_stop;
        logic             small_letter;
        logic             capital_letter;
        logic             number;
        logic             hex_digit;
        logic             punctuation_basic;
        logic             punctuation_finance;
        logic             parentheses;
        logic             curly_braces;
        logic             math_symbol;
        logic             whitespace;
        logic             vowel;
        logic             consonant;
        logic             other;
        logic             verify_error;
        logic [LEN_W-1:0] str_len;
    } entry_t;

    entry_t           new_entry;
    entry_t           head_q, head_d, tail_q, tail_d;
    logic [1:0]       count_q, count_d;
    logic             valid_q, in_ready_q;
    logic [LEN_W-1:0] len_q, len_d;
    logic             ovf_q, ovf_d;
    logic             wr, rd;

    assign wr = in_valid & in_ready_q;
    assign rd = valid_q & out_ready;

    // Class flags and length check for the byte currently offered
    always_comb begin
        new_entry = '0;
        len_d     = len_q;
        ovf_d     = ovf_q;

        new_entry.start_stop     = (in_data == 8'h00);
        new_entry.small_letter   = (in_data >= 8'h61) && (in_data <= 8'h7A);
        new_entry.capital_letter = (in_data >= 8'h41) && (in_data <= 8'h5A);
        new_entry.number         = (in_data >= 8'h30) && (in_data <= 8'h39);
        new_entry.hex_digit      = new_entry.number
                                 || ((in_data >= 8'h41) && (in_data <= 8'h46))
                                 || ((in_data >= 8'h61) && (in_data <= 8'h66));
        case (in_data)
            8'h2E, 8'h2C, 8'h3A, 8'h3B, 8'h21, 8'h3F, 8'h27, 8'h22: new_entry.punctuation_basic   = 1'b1;
            8'h23, 8'h24, 8'h25, 8'h26, 8'h40:                      new_entry.punctuation_finance = 1'b1;
            8'h28, 8'h29, 8'h5B, 8'h5D:                             new_entry.parentheses         = 1'b1;
            8'h7B, 8'h7D:                                           new_entry.curly_braces        = 1'b1;
            8'h2B, 8'h2D, 8'h2A, 8'h2F, 8'h5C, 8'h3D, 8'h3C, 8'h3E: new_entry.math_symbol         = 1'b1;
            8'h20, 8'h09, 8'h0A, 8'h0D:                             new_entry.whitespace          = 1'b1;
            8'h61, 8'h65, 8'h69, 8'h6F, 8'h75,
            8'h41, 8'h45, 8'h49, 8'h4F, 8'h55:                      new_entry.vowel               = 1'b1;
            default: ;
        endcase
        new_entry.consonant = (new_entry.small_letter | new_entry.capital_letter) & ~new_entry.vowel;
        new_entry.other = ~(new_entry.start_stop | new_entry.small_letter | new_entry.capital_letter
                          | new_entry.number | new_entry.punctuation_basic | new_entry.punctuation_finance
                          | new_entry.parentheses | new_entry.curly_braces | new_entry.math_symbol
                          | new_entry.whitespace);

        if (new_entry.start_stop) begin
            new_entry.str_len      = '0;
            new_entry.verify_error = 1'b0;
            if (wr) begin
                len_d = '0;
                ovf_d = 1'b0;
            end
        end else if (len_q < LEN_W'(MAX_LEN)) begin
            new_entry.str_len      = len_q + LEN_W'(1);
            new_entry.verify_error = ovf_q | in_data[7];
            if (wr) len_d = len_q + LEN_W'(1);
        end else begin
            // saturated: this byte and the rest of the string are flagged
            new_entry.str_len      = len_q;
            new_entry.verify_error = 1'b1;
            if (wr) ovf_d = 1'b1;
        end
    end

    // FIFO next state; the head register is zeroed whenever the FIFO is empty
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (count_q)
            2'd0: begin
                if (wr) begin
                    head_d  = new_entry;
                    count_d = 2'd1;
                end
            end
            2'd1: begin
                if (wr && rd) begin
                    head_d = new_entry;
                end else if (wr) begin
                    tail_d  = new_entry;
                    count_d = 2'd2;
                end else if (rd) begin
                    head_d  = '0;
                    count_d = 2'd0;
                end
            end
            2'd2: begin
                if (rd) begin
                    head_d  = tail_q;
                    tail_d  = '0;
                    count_d = 2'd1;
                end
            end
            default: begin
                head_d  = '0;
                tail_d  = '0;
                count_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q    <= 2'd0;
            head_q     <= '0;
            tail_q     <= '0;
            valid_q    <= 1'b0;
            in_ready_q <= 1'b0;
            len_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            valid_q    <= (count_d != 2'd0);
            in_ready_q <= (count_d != 2'd2);
            len_q      <= len_d;
            ovf_q      <= ovf_d;
        end
    end

    assign in_ready            = in_ready_q;
    assign valid               = valid_q;
    assign start_stop          = head_q.start_stop;
    assign small_letter        = head_q.small_letter;
    assign capital_letter      = head_q.capital_letter;
    assign number              = head_q.number;
    assign hex_digit           = head_q.hex_digit;
    assign punctuation_basic   = head_q.punctuation_basic;
    assign punctuation_finance = head_q.punctuation_finance;
    assign parentheses         = head_q.parentheses;
    assign curly_braces        = head_q.curly_braces;
    assign math_symbol         = head_q.math_symbol;
    assign whitespace          = head_q.whitespace;
    assign vowel               = head_q.vowel;
    assign consonant           = head_q.consonant;
    assign other               = head_q.other;
    assign verify_error        = head_q.verify_error;
    assign str_len             = head_q.str_len;

endmodule

// File: tb/tb_char_classifier.sv
// Directed and randomized checks of char_classifier against hand-computed vectors
// and an independent reference classifier with a queue scoreboard.
module tb_char_classifier;

    localparam logic [13:0] F_SS  = 14'h2000, F_SM  = 14'h1000, F_CAP = 14'h0800, F_NUM = 14'h0400;
    localparam logic [13:0] F_HEX = 14'h0200, F_PB  = 14'h0100, F_PF  = 14'h0080, F_PAR = 14'h0040;
    localparam logic [13:0] F_CUR = 14'h0020, F_MTH = 14'h0010, F_WS  = 14'h0008, F_VOW = 14'h0004;
    localparam logic [13:0] F_CON = 14'h0002, F_OTH = 14'h0001;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, valid;
    logic       start_stop, small_letter, capital_letter, number, hex_digit;
    logic       punctuation_basic, punctuation_finance, parentheses, curly_braces;
    logic       math_symbol, whitespace, vowel, consonant, other, verify_error;
    logic [3:0] str_len;
    logic [18:0] obs;

    int total = 0;
    int bad   = 0;
    int m_len = 0;
    bit m_ovf = 1'b0;

    char_classifier #(.MAX_LEN(15), .LEN_W(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_ready(out_ready), .valid(valid), .start_stop(start_stop), .small_letter(small_letter),
        .capital_letter(capital_letter), .number(number), .hex_digit(hex_digit),
        .punctuation_basic(punctuation_basic), .punctuation_finance(punctuation_finance),
        .parentheses(parentheses), .curly_braces(curly_braces), .math_symbol(math_symbol),
        .whitespace(whitespace), .vowel(vowel), .consonant(consonant), .other(other),
        .verify_error(verify_error), .str_len(str_len)
    );

    always #5 clk = ~clk;

    assign obs = {start_stop, small_letter, capital_letter, number, hex_digit, punctuation_basic,
                  punctuation_finance, parentheses, curly_braces, math_symbol, whitespace,
                  vowel, consonant, other, verify_error, str_len};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [19:0] observed, input logic [19:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic expect_head(input string tag, input logic [13:0] flags, input logic err,
                               input logic [3:0] len);
        check(tag, {valid, obs}, {1'b1, flags, err, len});
    endtask

    // Reference classifier written from the character tables, with its own length tracker
    function automatic logic [18:0] model(input logic [7:0] b);
        logic ss, sm, cap, num, hex, pb, pf, par, cur, mth, ws, vow, con, oth, err;
        logic [3:0] len;
        ss  = (b == 8'h00);
        sm  = (b inside {["a":"z"]});
        cap = (b inside {["A":"Z"]});
        num = (b inside {["0":"9"]});
        hex = num || (b inside {["a":"f"], ["A":"F"]});
        pb  = (b inside {".", ",", ":", ";", "!", "?", 8'h27, 8'h22});
        pf  = (b inside {"#", "$", "%", "&", "@"});
        par = (b inside {"(", ")", "[", "]"});
        cur = (b inside {"{", "}"});
        mth = (b inside {"+", "-", "*", "/", 8'h5C, "=", "<", ">"});
        ws  = (b inside {8'h20, 8'h09, 8'h0A, 8'h0D});
        vow = (b inside {"a", "e", "i", "o", "u", "A", "E", "I", "O", "U"});
        con = (sm || cap) && !vow;
        oth = !(ss || sm || cap || num || pb || pf || par || cur || mth || ws);
        if (ss) begin
            m_len = 0; m_ovf = 1'b0; len = 4'd0; err = 1'b0;
        end else if (m_len < 15) begin
            m_len++; len = 4'(m_len); err = m_ovf || b[7];
        end else begin
            m_ovf = 1'b1; len = 4'd15; err = 1'b1;
        end
        return {ss, sm, cap, num, hex, pb, pf, par, cur, mth, ws, vow, con, oth, err, len};
    endfunction

    logic [7:0]  s1 [6];
    logic [13:0] f1 [6];
    logic [3:0]  l1 [6];
    logic [18:0] q[$];

    initial begin
        // reset state
        #2 rst = 1'b1;
        #1 check("reset_state", {valid, in_ready, obs[17:0]}, 20'h0);
        step();
        check("reset_hold", {valid, in_ready, obs[17:0]}, 20'h0);
        #4 rst = 1'b0;
        step();
        check("ready_after_rst", 20'(in_ready), 20'h1);
        check("empty_after_rst", 20'(valid), 20'h0);

        // back-to-back stream with free-running consumer
        s1 = '{8'h00, "1", "2", "+", "A", 8'h00};
        f1 = '{F_SS, F_NUM|F_HEX, F_NUM|F_HEX, F_MTH, F_CAP|F_HEX|F_VOW, F_SS};
        l1 = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = s1[i];
            check("stream_ready", 20'(in_ready), 20'h1);
            step();
            expect_head("stream_head", f1[i], 1'b0, l1[i]);
        end
        in_valid = 1'b0;
        step();
        check("stream_drained", 20'(valid), 20'h0);

        // backpressure: third byte held until consumer resumes
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = "a";
        step();
        expect_head("bp_a", F_SM|F_HEX|F_VOW, 1'b0, 4'd1);
        check("bp_ready1", 20'(in_ready), 20'h1);
        in_data = "b";
        step();
        check("bp_full", 20'(in_ready), 20'h0);
        in_data = "c";
        step();
        step();
        expect_head("bp_hold", F_SM|F_HEX|F_VOW, 1'b0, 4'd1);
        check("bp_still_full", 20'(in_ready), 20'h0);
        out_ready = 1'b1;
        step();
        expect_head("bp_b", F_SM|F_HEX|F_CON, 1'b0, 4'd2);
        step();
        expect_head("bp_c", F_SM|F_HEX|F_CON, 1'b0, 4'd3);
        in_valid = 1'b0;
        step();
        check("bp_drained", 20'(valid), 20'h0);

        // overlong string: 16 'b' after a terminator
        in_valid = 1'b1; in_data = 8'h00;
        step();
        expect_head("ovf_nul", F_SS, 1'b0, 4'd0);
        for (int k = 1; k <= 16; k++) begin
            in_data = "b";
            step();
            expect_head("ovf_b", F_SM|F_HEX|F_CON, (k == 16), (k == 16) ? 4'd15 : 4'(k));
        end
        in_data = 8'h00;
        step();
        expect_head("ovf_clear_nul", F_SS, 1'b0, 4'd0);
        in_data = "b";
        step();
        expect_head("ovf_next_str", F_SM|F_HEX|F_CON, 1'b0, 4'd1);

        // non-ASCII and misc classes
        in_data = 8'hC8;
        step();
        expect_head("non_ascii", F_OTH, 1'b1, 4'd2);
        in_data = "@";
        step();
        expect_head("finance", F_PF, 1'b0, 4'd3);
        in_data = "{";
        step();
        expect_head("curly", F_CUR, 1'b0, 4'd4);
        in_data = 8'h09;
        step();
        expect_head("tab", F_WS, 1'b0, 4'd5);
        in_valid = 1'b0;
        step();

        // asynchronous reset with two buffered entries
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = "x";
        step();
        in_data = "y";
        step();
        in_valid = 1'b0;
        expect_head("pre_rst_head", F_SM|F_CON, 1'b0, 4'd6);
        check("pre_rst_full", 20'(in_ready), 20'h0);
        #3 rst = 1'b1;
        #1 check("async_rst", {valid, in_ready, obs[17:0]}, 20'h0);
        step();
        check("rst_held", {valid, in_ready, obs[17:0]}, 20'h0);
        #2 rst = 1'b0;
        step();
        check("ready_after_rst2", 20'(in_ready), 20'h1);
        check("empty_after_rst2", 20'(valid), 20'h0);
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = "x";
        step();
        expect_head("fresh_len", F_SM|F_CON, 1'b0, 4'd1);
        in_valid = 1'b0;
        step();

        // random handshakes against the reference model
        begin
            int sent = 0;
            int cyc  = 0;
            bit acc, rd;
            logic [7:0] b;
            m_len = 1;
            m_ovf = 1'b0;
            in_data = 8'h00;
            while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
                check("rnd_valid", 20'(valid), 20'(q.size() != 0));
                check("rnd_ready", 20'(in_ready), 20'(q.size() < 2));
                if (valid && q.size() != 0) check("rnd_head", 20'(obs), 20'(q[0]));
                acc = in_valid && in_ready;
                rd  = valid && out_ready;
                b   = in_data;
                step();
                cyc++;
                if (rd && q.size() != 0) void'(q.pop_front());
                if (acc) begin
                    q.push_back(model(b));
                    sent++;
                end
                in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
                out_ready = ($urandom_range(0, 2) != 0);
                in_data   = ($urandom_range(0, 12) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            end
            check("rnd_complete", 20'(sent), 20'd1000);
            check("rnd_queue_empty", 20'(q.size()), 20'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
